// File: rtl/flop_equiv_monitor.sv
// Scores a spec flop against its translated impl flop every cycle after a warmup window.
// Data is four-valued in two planes (val, x). The block counts mismatches and records the first one.
module flop_equiv_monitor #(
  parameter int WIDTH  = 4,
  parameter int WARMUP = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             approx,
  input  logic [WIDTH-1:0] spec_val,
  input  logic [WIDTH-1:0] spec_x,
  input  logic [WIDTH-1:0] impl_val,
  input  logic [WIDTH-1:0] impl_x,
  output logic             checking,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_fail_cyc,
  output logic [WIDTH-1:0] first_fail_mask
);

  localparam int WU_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WARM  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic             chk_q, chk_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] mmc_q, mmc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ffc_q, ffc_d;
  logic [WIDTH-1:0] ffm_q, ffm_d;

  logic [WIDTH-1:0] exact, ok, mm;
  logic             bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A spec X only matches an impl X; an impl X is forgiven in approx mode.
  always_comb begin
    exact = ~(spec_x ^ impl_x) & (spec_x | ~(spec_val ^ impl_val));
    ok    = exact | ({WIDTH{approx}} & impl_x);
    mm    = ~ok;
    bad   = |mm;
  end

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    fail_d  = fail_q;
    mmc_d   = mmc_q;
    cyc_d   = cyc_q;
    ffc_d   = ffc_q;
    ffm_d   = ffm_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WARM;
          wu_d    = WU_W'(WARMUP);
          fail_d  = 1'b0;
          mmc_d   = '0;
          cyc_d   = '0;
          ffc_d   = '0;
          ffm_d   = '0;
        end
      end
      S_WARM: begin
        if (stop)              state_d = S_IDLE;
        else if (wu_q == '0)   state_d = S_CHECK;
        else                   wu_d    = wu_q - WU_W'(1);
      end
      S_CHECK: begin
        cyc_d = sat_inc(cyc_q);
        if (bad) begin
          mmc_d  = sat_inc(mmc_q);
          fail_d = 1'b1;
          if (!fail_q) begin
            ffc_d = cyc_q;
            ffm_d = mm;
          end
        end
        if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    chk_d = (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wu_q    <= '0;
      chk_q   <= 1'b0;
      fail_q  <= 1'b0;
      mmc_q   <= '0;
      cyc_q   <= '0;
      ffc_q   <= '0;
      ffm_q   <= '0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
      chk_q   <= chk_d;
      fail_q  <= fail_d;
      mmc_q   <= mmc_d;
      cyc_q   <= cyc_d;
      ffc_q   <= ffc_d;
      ffm_q   <= ffm_d;
    end
  end

  assign checking        = chk_q;
  assign fail            = fail_q;
  assign mismatch_cnt    = mmc_q;
  assign cycle_cnt       = cyc_q;
  assign first_fail_cyc  = ffc_q;
  assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_flop_equiv_monitor.sv
// Bench for flop_equiv_monitor: a 16-bit and a 4-bit counter instance share the same stimulus.
// Both are compared against a run-level reference model plus fixed vectors and corner sequences.
module tb_flop_equiv_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stop, approx;
  logic [3:0] sv, sx, iv, ix;

  logic        chk_a, fail_a;
  logic [15:0] mmc_a, cyc_a, ffc_a;
  logic [3:0]  ffm_a;
  logic        chk_b, fail_b;
  logic [3:0]  mmc_b, cyc_b, ffc_b;
  logic [3:0]  ffm_b;

  flop_equiv_monitor #(.WIDTH(4), .WARMUP(10), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .approx(approx),
    .spec_val(sv), .spec_x(sx), .impl_val(iv), .impl_x(ix),
    .checking(chk_a), .fail(fail_a), .mismatch_cnt(mmc_a), .cycle_cnt(cyc_a),
    .first_fail_cyc(ffc_a), .first_fail_mask(ffm_a)
  );

  flop_equiv_monitor #(.WIDTH(4), .WARMUP(10), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .approx(approx),
    .spec_val(sv), .spec_x(sx), .impl_val(iv), .impl_x(ix),
    .checking(chk_b), .fail(fail_b), .mismatch_cnt(mmc_b), .cycle_cnt(cyc_b),
    .first_fail_cyc(ffc_b), .first_fail_mask(ffm_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a run is idle, warming up or checking; counts are unbounded integers.
  bit running, warming;
  int warm_left, m_cyc, m_mmc, m_ffc, m_ffm;
  bit m_fail;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic int bad_bits();
    int m = 0;
    for (int i = 0; i < 4; i++) begin
      bit both_x    = sx[i] && ix[i];
      bit both_eq   = !sx[i] && !ix[i] && (sv[i] == iv[i]);
      bit forgiven  = approx && ix[i];
      if (!(both_x || both_eq || forgiven)) m |= (1 << i);
    end
    return m;
  endfunction

  task automatic model_step();
    if (reset) begin
      running = 0; warming = 0; warm_left = 0;
      m_cyc = 0; m_mmc = 0; m_ffc = 0; m_ffm = 0; m_fail = 0;
    end else if (!running && !warming) begin
      if (start) begin
        warming = 1; warm_left = 10;
        m_cyc = 0; m_mmc = 0; m_ffc = 0; m_ffm = 0; m_fail = 0;
      end
    end else if (warming) begin
      if (stop) warming = 0;
      else if (warm_left == 0) begin warming = 0; running = 1; end
      else warm_left--;
    end else begin
      int m = bad_bits();
      if (m != 0) begin
        if (!m_fail) begin m_ffc = m_cyc; m_ffm = m; end
        m_fail = 1;
        m_mmc++;
      end
      m_cyc++;
      if (stop) running = 0;
    end
  endtask

  task automatic check_all();
    cmp("a.checking", chk_a, running);
    cmp("a.fail", fail_a, m_fail);
    cmp("a.mismatch_cnt", mmc_a, sat(m_mmc, 65535));
    cmp("a.cycle_cnt", cyc_a, sat(m_cyc, 65535));
    cmp("a.first_fail_cyc", ffc_a, sat(m_ffc, 65535));
    cmp("a.first_fail_mask", ffm_a, m_ffm);
    cmp("b.checking", chk_b, running);
    cmp("b.fail", fail_b, m_fail);
    cmp("b.mismatch_cnt", mmc_b, sat(m_mmc, 15));
    cmp("b.cycle_cnt", cyc_b, sat(m_cyc, 15));
    cmp("b.first_fail_cyc", ffc_b, sat(m_ffc, 15));
    cmp("b.first_fail_mask", ffm_b, m_ffm);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic ap);
    sv = a; sx = b; iv = c; ix = d; approx = ap;
  endtask

  // Start pulse plus the 11 cycles it takes for checking to come up.
  task automatic run_to_check();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 11; k++) tick();
  endtask

  typedef struct {
    logic [3:0] sv, sx, iv, ix;
    logic       ap;
    logic [3:0] mm;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int lat;
    tbl[0] = '{4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b0, 4'b0000};
    tbl[1] = '{4'b1010, 4'b0000, 4'b1110, 4'b0000, 1'b0, 4'b0100};
    tbl[2] = '{4'b0110, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0000};
    tbl[3] = '{4'b0110, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b1111};
    tbl[4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    tbl[5] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001};
    tbl[6] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0000};
    tbl[7] = '{4'b0000, 4'b0011, 4'b0000, 4'b0101, 1'b1, 4'b0010};
    tbl[8] = '{4'b0000, 4'b0011, 4'b0000, 4'b0101, 1'b0, 4'b0110};

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    running = 0; warming = 0; warm_left = 0;
    m_cyc = 0; m_mmc = 0; m_ffc = 0; m_ffm = 0; m_fail = 0;
    tick(); tick();
    reset = 1'b0;
    cmp("reset.fail", fail_a, 0);
    cmp("reset.cycle_cnt", cyc_a, 0);

    // Clean run: latency of checking and a 20-cycle pass.
    set_in(4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    lat = 0;
    while (!chk_a && lat < 50) begin tick(); lat++; end
    cmp("t1.latency", lat, 11);
    for (int k = 0; k < 20; k++) begin stop = (k == 19); tick(); end
    stop = 1'b0;
    cmp("t1.fail", fail_a, 0);
    cmp("t1.mismatch_cnt", mmc_a, 0);
    cmp("t1.cycle_cnt", cyc_a, 20);
    cmp("t1.checking", chk_a, 0);

    // Single flip on bit2 at cycle_cnt=5.
    run_to_check();
    for (int k = 0; k < 8; k++) begin
      iv = (k == 5) ? 4'b1110 : 4'b1010;
      stop = (k == 7);
      tick();
    end
    stop = 1'b0; iv = 4'b1010;
    cmp("t2.fail", fail_a, 1);
    cmp("t2.mismatch_cnt", mmc_a, 1);
    cmp("t2.first_fail_cyc", ffc_a, 5);
    cmp("t2.first_fail_mask", ffm_a, 4'b0100);
    tick(); tick();
    cmp("t2.hold_fail", fail_a, 1);

    // Bit-compare vectors, one CHECK cycle each.
    for (int t = 0; t < 9; t++) begin
      do_reset();
      set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      run_to_check();
      set_in(tbl[t].sv, tbl[t].sx, tbl[t].iv, tbl[t].ix, tbl[t].ap);
      stop = 1'b1; tick(); stop = 1'b0;
      cmp($sformatf("vec%0d.fail", t), fail_a, (tbl[t].mm != 4'b0000));
      cmp($sformatf("vec%0d.mask", t), ffm_a, tbl[t].mm);
    end

    // Mismatches only during warmup, plus one on the stop cycle.
    do_reset();
    set_in(4'b1010, 4'b0000, 4'b0101, 4'b0000, 1'b0);
    run_to_check();
    iv = 4'b1010;
    for (int k = 0; k < 3; k++) tick();
    iv = 4'b1011; stop = 1'b1; tick(); stop = 1'b0;
    cmp("t5.mismatch_cnt", mmc_a, 1);
    cmp("t5.first_fail_cyc", ffc_a, 3);
    cmp("t5.cycle_cnt", cyc_a, 4);

    // Stop during warmup, then start+stop together in IDLE.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    stop = 1'b1; tick();
    cmp("warmstop.cycle_cnt", cyc_a, 0);
    start = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    cmp("startstop.checking", chk_a, 1);

    // Saturation on the 4-bit instance, then reset mid-CHECK.
    do_reset();
    set_in(4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0);
    run_to_check();
    for (int k = 0; k < 22; k++) tick();
    cmp("t6.b_mismatch_cnt", mmc_b, 15);
    cmp("t6.b_cycle_cnt", cyc_b, 15);
    cmp("t6.b_fail", fail_b, 1);
    cmp("t6.a_mismatch_cnt", mmc_a, 22);
    reset = 1'b1; tick(); reset = 1'b0;
    cmp("t6.rst_checking", chk_b, 0);
    cmp("t6.rst_mismatch", mmc_b, 0);
    cmp("t6.rst_fail", fail_a, 0);
    cmp("t6.rst_mask", ffm_a, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      reset  = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 24) == 0);
      approx = $urandom_range(0, 1);
      sv = 4'($urandom);
      sx = 4'($urandom) & 4'($urandom) & 4'($urandom);
      iv = ($urandom_range(0, 5) == 0) ? 4'($urandom) : sv;
      ix = ($urandom_range(0, 5) == 0) ? (4'($urandom) & 4'($urandom)) : sx;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
